hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Per-register pending-write scoreboard for ID-stage stall generation; successor to the fixed EXE/MEM compare.
//  Tracks NUM_REGS destination registers, each with a countdown of cycles until its result is forwardable.
//  Supports variable-latency producers (load, multi-cycle ALU) and in-order writeback.
//  Sits beside the ID/EXE pipeline register and drives the stall line to PC, IF/ID and ID/EXE.
// PARAMETERS
//  REG_AW    5   register address width
//  NUM_REGS  32  architectural registers tracked (<= 2**REG_AW); r0 never pending
//  LAT_W     3   width of latency field / per-register counter (max latency 2**LAT_W-1)
//  WB_DEPTH  2   cycles from EXE entry to register-file write (no-forward mode latency)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  forward_EN     in   1      1 = forwarding active; 0 = operands only from register file
//  issue_valid    in   1      ID instruction requests to advance into EXE this cycle
//  src1_ID        in   REG_AW source register 1
//  src2_ID        in   REG_AW source register 2
//  src2_valid     in   1      src2 is a register (R-type, store, BNE), not immediate
//  branch_comm    in   2      branch type; BEZ and BNE resolve in ID
//  dest_ID        in   REG_AW destination of issuing instruction
//  wb_en_ID       in   1      issuing instruction writes dest_ID
//  lat_ID         in   LAT_W  cycles until result forwardable (1 = ALU, 2 = load, ...)
//  flush          in   1      pipeline flush (taken branch/exception): cancel all pending writes
//  hazard_detected out 1      stall ID this cycle
//  pend_vec       out NUM_REGS debug: bit r set when pend_cnt[r] != 0
// BEHAVIOUR
//  - State: pend_cnt[r] (LAT_W bits) per register. Reset: all 0; hazard_detected=0, pend_vec=0.
//  - Every cycle each nonzero pend_cnt decrements by 1 (saturates at 0).
//  - Required count for operand s: need = (forward_EN && !is_branch) ? 1 : 0;
//    is_branch = branch_comm==BEZ(1) || branch_comm==BNE(3).
//  - hazard_detected (combinational from state+inputs) = issue_valid &&
//    ((pend_cnt[src1_ID] > need) || (src2_valid && pend_cnt[src2_ID] > need)); src 0 never hazards.
//  - Allocation: fire = issue_valid && !hazard_detected && !flush && wb_en_ID && dest_ID != 0.
//    On fire, next pend_cnt[dest_ID] = forward_EN ? lat_ID : WB_DEPTH (no decrement that cycle).
//  - WAW: if pend_cnt[dest_ID] is nonzero, next = max(pend_cnt-1, new latency); never shortens.
//  - lat_ID == 0 on fire treated as 1.
//  - flush: all counters cleared next cycle; has priority over allocation and decrement.
//  - rst mid-operation: same as flush plus stats cleared; next cycle no hazard.
//  - Stalled instruction re-presents next cycle; no allocation until stall drops.
//  - Latency: allocation at edge N -> dependent ALU op stalls for lat-1 cycles when forwarding, WB_DEPTH otherwise.
//  - dest_ID/src addresses >= NUM_REGS: never allocate, never hazard.
// CONFIGURATION
//  HAZARD_STALL_STATS_EN defined: adds outputs stall_cycles (32b, wraps) and max_stall_run (16b, saturating);
//   stall_cycles += 1 each cycle hazard_detected=1; run counter tracks consecutive stalls, max updated at run end
//   or while running; both cleared by rst only (not flush).
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  hazard_pkg: BR_NONE/BR_BEZ=1/BR_BNE=3 encodings, LAT_ALU=1, LAT_LOAD=2, default widths.
//  Sub-module hazard_pend_counter: one LAT_W down-counter with load/max/clear; generated NUM_REGS times.
//  Top holds source-compare muxing, allocation decode and optional stats.
// TESTING
//  1 ALU RAW, fwd on: alloc r3 lat=1, next cycle src1=r3 -> hazard_detected=0.
//  2 Load-use, fwd on: alloc r5 lat=2, next src2=r5 src2_valid=1 -> 1 stall cycle, then 0.
//  3 Branch, fwd on: alloc r4 lat=1, next BNE src1=r4 -> stall 1 cycle; fwd off, alloc r4 -> stall WB_DEPTH=2 cycles.
//  4 Immediate: pend r7, src2=r7 src2_valid=0, src1=r1 -> no stall; src1=r0 with r0 written -> no stall.
//  5 WAW+flush: alloc r2 lat=4, 1 cycle later alloc r2 lat=1 -> pend_cnt[r2]=3; flush -> pend_vec=0 next cycle.
//  6 Stats (HAZARD_STALL_STATS_EN): 3 stall cycles, gap, 2 stall cycles -> stall_cycles=5, max_stall_run=3.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and default widths for the pending-write hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int REG_AW_D   = 5;
  localparam int NUM_REGS_D = 32;
  localparam int LAT_W_D    = 3;
  localparam int WB_DEPTH_D = 2;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  typedef enum logic [1:0] {
    BR_NONE  = 2'd0,
    BR_BEZ   = 2'd1,
    BR_OTHER = 2'd2,
    BR_BNE   = 2'd3
  } branch_e;

  // BEZ/BNE compare in ID, so their operands must be fully written back
  function automatic logic is_id_branch(input logic [1:0] br);
    return (br == BR_BEZ) || (br == BR_BNE);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bus between the decode stage (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3
);
  logic                forward_EN;
  logic                flush;
  logic                issue_valid;
  logic [REG_AW-1:0]   src1_ID;
  logic [REG_AW-1:0]   src2_ID;
  logic                src2_valid;
  logic [1:0]          branch_comm;
  logic [REG_AW-1:0]   dest_ID;
  logic                wb_en_ID;
  logic [LAT_W-1:0]    lat_ID;
  logic                hazard_detected;
  logic [NUM_REGS-1:0] pend_vec;

  modport master (
    output forward_EN, flush, issue_valid, src1_ID, src2_ID, src2_valid,
           branch_comm, dest_ID, wb_en_ID, lat_ID,
    input  hazard_detected, pend_vec
  );

  modport slave (
    input  forward_EN, flush, issue_valid, src1_ID, src2_ID, src2_valid,
           branch_comm, dest_ID, wb_en_ID, lat_ID,
    output hazard_detected, pend_vec
  );
endinterface

// File: rtl/hazard_scoreboard_pend_counter.sv
// One per-register pending-write countdown: decrements to 0, loads max(cnt-1, new), clears on flush.
module hazard_pend_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt
);
  logic [LAT_W-1:0] dec;

  assign dec = (cnt == '0) ? '0 : cnt - 1'b1;

  // A younger writer never shortens an older, slower one still in flight
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (load)   cnt <= (dec > load_val) ? dec : load_val;
    else             cnt <= dec;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard driving the ID stall line.
// Optional HAZARD_STALL_STATS_EN adds stall_cycles / max_stall_run counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int LAT_W    = LAT_W_D,
  parameter int WB_DEPTH = WB_DEPTH_D
) (
  input  logic clk,
  input  logic rst,
  hazard_scoreboard_if.slave bus
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] max_stall_run
`endif
);
  logic [NUM_REGS-1:0][LAT_W-1:0] pend_cnt;
  logic [LAT_W-1:0] cnt1, cnt2, need, alloc_lat;
  logic             hazard, fire;

  // Sources outside 1..NUM_REGS-1 never match, so they read as not pending
  always_comb begin
    cnt1 = '0;
    cnt2 = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (bus.src1_ID == REG_AW'(r)) cnt1 = pend_cnt[r];
      if (bus.src2_ID == REG_AW'(r)) cnt2 = pend_cnt[r];
    end
  end

  assign need   = (bus.forward_EN && !is_id_branch(bus.branch_comm)) ? LAT_W'(1) : '0;
  assign hazard = bus.issue_valid &&
                  ((cnt1 > need) || (bus.src2_valid && (cnt2 > need)));
  assign bus.hazard_detected = hazard;

  assign fire = bus.issue_valid && !hazard && !bus.flush &&
                bus.wb_en_ID && (bus.dest_ID != '0);

  assign alloc_lat = !bus.forward_EN      ? LAT_W'(WB_DEPTH) :
                     (bus.lat_ID == '0)   ? LAT_W'(1)        : bus.lat_ID;

  // r0 gets a counter too, but its load is never asserted
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    hazard_pend_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.flush),
      .load     (fire && (bus.dest_ID == REG_AW'(r))),
      .load_val (alloc_lat),
      .cnt      (pend_cnt[r])
    );
  end

  always_comb begin
    bus.pend_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) bus.pend_vec[r] = |pend_cnt[r];
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] run, run_inc;

  assign run_inc = (run == 16'hFFFF) ? run : run + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      run           <= '0;
      max_stall_run <= '0;
    end else if (hazard) begin
      stall_cycles <= stall_cycles + 32'd1;
      run          <= run_inc;
      if (run_inc > max_stall_run) max_stall_run <= run_inc;
    end else begin
      run <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with an expected-value queue per cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .NUM_REGS(32), .LAT_W(3)) hif ();

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] max_stall_run;
`endif

  hazard_scoreboard #(.REG_AW(5), .NUM_REGS(32), .LAT_W(3), .WB_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .max_stall_run (max_stall_run)
`endif
  );

  typedef struct {
    logic        rst, fwd, flush, iv;
    logic [4:0]  s1, s2;
    logic        s2v;
    logic [1:0]  br;
    logic [4:0]  d;
    logic        we;
    logic [2:0]  lat;
    logic        eh;
    logic [31:0] ep;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input bit r, input bit f, input bit fl, input bit iv,
                              input int s1, input int s2, input bit s2v, input int br,
                              input int d, input bit we, input int lat,
                              input bit eh, input int ep, input string nm);
    vec_t v;
    v.rst = r;  v.fwd = f;  v.flush = fl; v.iv = iv;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.s2v = s2v; v.br = 2'(br);
    v.d = 5'(d); v.we = we; v.lat = 3'(lat);
    v.eh = eh; v.ep = 32'(ep); v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge
  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst;
    hif.forward_EN = v.fwd;   hif.flush = v.flush;   hif.issue_valid = v.iv;
    hif.src1_ID = v.s1;       hif.src2_ID = v.s2;    hif.src2_valid = v.s2v;
    hif.branch_comm = v.br;   hif.dest_ID = v.d;     hif.wb_en_ID = v.we;
    hif.lat_ID = v.lat;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: expectation queue empty", v.nm);
    end else begin
      e = exp_q.pop_front();
      check({e.nm, ".hazard"}, {31'd0, hif.hazard_detected}, {31'd0, e.eh});
      check({e.nm, ".pend_vec"}, hif.pend_vec, e.ep);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //      rst f fl iv s1 s2 s2v br      d  we lat       eh pend
    // ALU RAW with forwarding: no stall
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 3,1,LAT_ALU, 0,'h0,   "t1_alloc_r3"));
    tbl.push_back(mk(0,1,0,1, 3, 0,0,BR_NONE, 0,0,0,       0,'h8,   "t1_use_r3"));
    tbl.push_back(mk(0,1,0,0, 0, 0,0,BR_NONE, 0,0,0,       0,'h0,   "t1_idle"));
    // Load-use: one stall on src2
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 5,1,LAT_LOAD,0,'h0,   "t2_alloc_r5"));
    tbl.push_back(mk(0,1,0,1, 1, 5,1,BR_NONE, 0,0,0,       1,'h20,  "t2_use_stall"));
    tbl.push_back(mk(0,1,0,1, 1, 5,1,BR_NONE, 0,0,0,       0,'h20,  "t2_use_go"));
    // ID branch: 1 stall with forwarding, WB_DEPTH stalls without
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 4,1,LAT_ALU, 0,'h0,   "t3_alloc_r4"));
    tbl.push_back(mk(0,1,0,1, 4, 0,1,BR_BNE,  0,0,0,       1,'h10,  "t3_bne_stall"));
    tbl.push_back(mk(0,1,0,1, 4, 0,1,BR_BNE,  0,0,0,       0,'h0,   "t3_bne_go"));
    tbl.push_back(mk(0,0,0,1, 0, 0,0,BR_NONE, 4,1,LAT_ALU, 0,'h0,   "t3_nofwd_alloc"));
    tbl.push_back(mk(0,0,0,1, 4, 0,0,BR_NONE, 0,0,0,       1,'h10,  "t3_nofwd_stall1"));
    tbl.push_back(mk(0,0,0,1, 4, 0,0,BR_NONE, 0,0,0,       1,'h10,  "t3_nofwd_stall2"));
    tbl.push_back(mk(0,0,0,1, 4, 0,0,BR_NONE, 0,0,0,       0,'h0,   "t3_nofwd_go"));
    // Immediate operand and r0 never hazard; r0 never allocates
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 7,1,3,       0,'h0,   "t4_alloc_r7"));
    tbl.push_back(mk(0,1,0,1, 1, 7,0,BR_NONE, 0,1,3,       0,'h80,  "t4_imm_src2"));
    tbl.push_back(mk(0,1,0,1, 0, 0,1,BR_NONE, 0,0,0,       0,'h80,  "t4_r0_src"));
    tbl.push_back(mk(0,1,0,1, 7, 0,0,BR_NONE, 0,0,0,       0,'h80,  "t4_r7_fwd_ok"));
    // lat 0 behaves as 1; stalled instruction must not allocate r9
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 7,1,0,       0,'h0,   "b_lat0_alloc"));
    tbl.push_back(mk(0,1,0,1, 7, 0,0,BR_BEZ,  9,1,2,       1,'h80,  "b_lat0_bez"));
    tbl.push_back(mk(0,1,0,0, 0, 0,0,BR_NONE, 0,0,0,       0,'h0,   "b_stall_noalloc"));
    // WAW keeps the longer count (3), then flush clears and blocks allocation
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 2,1,4,       0,'h0,   "t5_alloc_r2_4"));
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 2,1,1,       0,'h4,   "t5_alloc_r2_1"));
    tbl.push_back(mk(0,1,0,1, 2, 0,0,BR_NONE, 0,0,0,       1,'h4,   "t5_waw_cnt3"));
    tbl.push_back(mk(0,1,0,1, 2, 0,0,BR_NONE, 0,0,0,       1,'h4,   "t5_waw_cnt2"));
    tbl.push_back(mk(0,1,0,1, 2, 0,0,BR_NONE, 0,0,0,       0,'h4,   "t5_waw_cnt1"));
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 2,1,4,       0,'h0,   "t5_realloc_r2"));
    tbl.push_back(mk(0,1,1,1, 0, 0,0,BR_NONE, 6,1,2,       0,'h4,   "t5_flush"));
    tbl.push_back(mk(0,1,0,0, 0, 0,0,BR_NONE, 0,0,0,       0,'h0,   "t5_after_flush"));
    // Reset mid-operation
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE, 8,1,5,       0,'h0,   "r_alloc_r8"));
    tbl.push_back(mk(1,1,0,0, 0, 0,0,BR_NONE, 0,0,0,       0,'h100, "r_reset"));
    tbl.push_back(mk(0,1,0,1, 8, 0,0,BR_NONE, 0,0,0,       0,'h0,   "r_after_reset"));
    // Stall runs of 3 and 2 separated by a gap
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE,10,1,4,       0,'h0,   "s_alloc_r10"));
    tbl.push_back(mk(0,1,0,1,10, 0,0,BR_NONE, 0,0,0,       1,'h400, "s_run1_a"));
    tbl.push_back(mk(0,1,0,1,10, 0,0,BR_NONE, 0,0,0,       1,'h400, "s_run1_b"));
    tbl.push_back(mk(0,1,0,1,10, 0,0,BR_NONE, 0,0,0,       1,'h400, "s_run1_c"));
    tbl.push_back(mk(0,1,0,1,10, 0,0,BR_NONE, 0,0,0,       0,'h400, "s_run1_end"));
    tbl.push_back(mk(0,1,0,0, 0, 0,0,BR_NONE, 0,0,0,       0,'h0,   "s_gap"));
    tbl.push_back(mk(0,1,0,1, 0, 0,0,BR_NONE,11,1,3,       0,'h0,   "s_alloc_r11"));
    tbl.push_back(mk(0,1,0,1,11, 0,0,BR_NONE, 0,0,0,       1,'h800, "s_run2_a"));
    tbl.push_back(mk(0,1,0,1,11, 0,0,BR_NONE, 0,0,0,       1,'h800, "s_run2_b"));
    tbl.push_back(mk(0,1,0,1,11, 0,0,BR_NONE, 0,0,0,       0,'h800, "s_run2_end"));

    hif.forward_EN = 1'b1; hif.flush = 1'b0; hif.issue_valid = 1'b0;
    hif.src1_ID = '0; hif.src2_ID = '0; hif.src2_valid = 1'b0;
    hif.branch_comm = BR_NONE; hif.dest_ID = '0; hif.wb_en_ID = 1'b0; hif.lat_ID = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

`ifdef HAZARD_STALL_STATS_EN
    @(negedge clk);
    check("stats.stall_cycles", stall_cycles, 32'd5);
    check("stats.max_stall_run", {16'd0, max_stall_run}, 32'd3);
    // Flush leaves the statistics alone; reset clears them
    apply(mk(0,1,1,0, 0,0,0,BR_NONE, 0,0,0, 0,'h0, "stats_flush"));
    check("stats.flush_keep", stall_cycles, 32'd5);
    apply(mk(1,1,0,0, 0,0,0,BR_NONE, 0,0,0, 0,'h0, "stats_reset"));
    check("stats.reset_cycles", stall_cycles, 32'd0);
    check("stats.reset_max", {16'd0, max_stall_run}, 32'd0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
